// File: rtl/spi_master_ctrl_if.sv
// Host-side request/response bundle for spi_master_ctrl (controller uses the slave modport).
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
);
  // Handshake: start is a one-cycle request, accepted only while the controller is idle
  // (busy=0, done=0); transfer settings are latched on that edge and start is otherwise
  // ignored, never queued. busy stays high until the cycle done pulses, and rx_data holds
  // the received word from the done cycle until the next completed transfer.
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [DIV_W-1:0]  baud_div;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  modport master (
    output start, tx_data, baud_div, cpol, cpha, lsb_first,
    input  busy, done, rx_data
  );

  modport slave (
    input  start, tx_data, baud_div, cpol, cpha, lsb_first,
    output busy, done, rx_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Single-word SPI master: IDLE -> SETUP -> XFER -> HOLD -> DONE with programmable mode/divider.
// Optional SPI_MASTER_CTRL_LOOPBACK_EN adds a loopback input that samples internal mosi instead of miso.
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
  input  logic             loopback,
`endif
  spi_master_ctrl_if.slave host,
  input  logic             miso,
  output logic             sck,
  output logic             mosi,
  output logic             ss_n,
  output logic [2:0]       dbg_state
);

  localparam int EDGE_W = $clog2(2*DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              phase_q, phase_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              mosi_q, mosi_d;
  logic              ss_n_q, ss_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              sample_bit;
  logic              cnt_zero;
  logic              sample_now;

`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
  assign sample_bit = loopback ? mosi_q : miso;
`else
  assign sample_bit = miso;
`endif

  assign cnt_zero = (cnt_q == '0);
  // A leading edge leaves the idle phase; cpha picks whether it samples or shifts.
  assign sample_now = (~phase_q) ^ cpha_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    phase_d   = phase_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    mosi_d    = mosi_q;

    case (state_q)
      S_IDLE: begin
        if (host.start) begin
          div_d   = host.baud_div;
          cpol_d  = host.cpol;
          cpha_d  = host.cpha;
          lsb_d   = host.lsb_first;
          cnt_d   = host.baud_div;
          edge_d  = '0;
          phase_d = 1'b0;
          rx_sr_d = '0;
          // cpha=0 presents the first bit before any edge; cpha=1 waits for the first leading edge.
          if (host.cpha) begin
            mosi_d  = 1'b0;
            tx_sr_d = host.tx_data;
          end else begin
            mosi_d  = host.lsb_first ? host.tx_data[0] : host.tx_data[DATA_W-1];
            tx_sr_d = host.lsb_first ? (host.tx_data >> 1) : (host.tx_data << 1);
          end
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_zero) begin
          cnt_d   = div_q;
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_XFER: begin
        if (cnt_zero) begin
          cnt_d   = div_q;
          phase_d = ~phase_q;
          edge_d  = edge_q + 1'b1;
          if (sample_now) begin
            rx_sr_d = lsb_q ? {sample_bit, rx_sr_q[DATA_W-1:1]}
                            : {rx_sr_q[DATA_W-2:0], sample_bit};
          end else begin
            mosi_d  = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
            tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
          end
          if (edge_q == LAST_EDGE) begin
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_HOLD: begin
        if (cnt_zero) begin
          rx_data_d = rx_sr_q;
          mosi_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        mosi_d  = 1'b0;
        edge_d  = '0;
        state_d = S_IDLE;
      end

      default: begin
        mosi_d  = 1'b0;
        phase_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Pin-level outputs are registered from the next state so they never glitch on decode.
    busy_d = (state_d == S_SETUP) || (state_d == S_XFER) || (state_d == S_HOLD);
    ss_n_d = ~busy_d;
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      edge_q    <= '0;
      phase_q   <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      phase_q   <= phase_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Idle level follows the most recently latched cpol, so reset parks sck low.
  assign sck          = phase_q ^ cpol_q;
  assign mosi         = mosi_q;
  assign ss_n         = ss_n_q;
  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.rx_data = rx_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: timing model from acceptance time, rx scoreboard, directed vectors.
module tb_spi_master_ctrl;
  localparam int DW = 8;

  logic       clk;
  logic       rst_n;
  logic       miso;
  logic       sck;
  logic       mosi;
  logic       ss_n;
  logic [2:0] dbg_state;
  int         miso_mode;  // 0: const 0, 1: tied to mosi, 2: inverted mosi, 3: const 1
`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
  logic       loopback;
`endif

  int n_checks = 0;
  int n_errors = 0;

  spi_master_ctrl_if #(.DATA_W(DW), .DIV_W(8)) host_if ();

  spi_master_ctrl #(.DATA_W(DW), .DIV_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
    .loopback  (loopback),
`endif
    .host      (host_if),
    .miso      (miso),
    .sck       (sck),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .dbg_state (dbg_state)
  );

  assign miso = (miso_mode == 1) ? mosi : (miso_mode == 2) ? ~mosi : (miso_mode == 3);

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // t counts cycles from the first busy cycle; P = baud_div+1.
  // SETUP occupies period 0, XFER periods 1..2N (an sck edge ends each one), HOLD period 2N+1,
  // done at t = (2N+2)*P.
  logic          m_active;
  int            m_t;
  int            m_p;
  logic [DW-1:0] m_tx;
  logic          m_pol, m_pha, m_lsb;
  logic [DW-1:0] m_rx_last;
  logic          m_pol_last;
  logic [DW-1:0] exp_q[$];

  function automatic logic exp_phase(input int t, input int p);
    int q;
    q = t / p;
    return (q >= 2) && (q <= 2*DW) && (q % 2 == 0);
  endfunction

  // Index (in transmission order) of the bit mosi must carry at t, or -1 when not constrained.
  function automatic int exp_idx(input int t, input int p, input logic pha);
    int q;
    q = t / p;
    if (!pha) return (q <= 1) ? 0 : ((q <= 2*DW) ? (q - 1) / 2 : -1);
    return (q >= 2 && q <= 2*DW) ? (q - 2) / 2 : -1;
  endfunction

  function automatic logic [DW-1:0] rx_expect(input logic [DW-1:0] tx, input int mode, input logic lb);
    if (lb || mode == 1) return tx;
    if (mode == 2) return ~tx;
    return (mode == 3) ? {DW{1'b1}} : {DW{1'b0}};
  endfunction

  function automatic logic lb_now();
`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
    return loopback;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active   <= 1'b0;
      m_t        <= 0;
      m_rx_last  <= '0;
      m_pol_last <= 1'b0;
      exp_q.delete();
    end else if (m_active) begin
      if (m_t + 1 > (2*DW + 2) * m_p) begin
        m_active <= 1'b0;
      end else begin
        m_t <= m_t + 1;
        if (m_t + 1 == (2*DW + 2) * m_p && exp_q.size() > 0) m_rx_last <= exp_q[0];
      end
    end else if (host_if.start) begin
      m_active   <= 1'b1;
      m_t        <= 0;
      m_p        <= int'(host_if.baud_div) + 1;
      m_tx       <= host_if.tx_data;
      m_pol      <= host_if.cpol;
      m_pha      <= host_if.cpha;
      m_lsb      <= host_if.lsb_first;
      m_pol_last <= host_if.cpol;
      exp_q.push_back(rx_expect(host_if.tx_data, miso_mode, lb_now()));
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    int t, idx, done_t;
    logic [DW-1:0] exp_rx;
    if (!rst_n) begin
      chk("rst_sck", sck, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_ss_n", ss_n, 1);
      chk("rst_busy", host_if.busy, 0);
      chk("rst_done", host_if.done, 0);
      chk("rst_rx", host_if.rx_data, 0);
    end else if (m_active) begin
      t      = m_t;
      done_t = (2*DW + 2) * m_p;
      if (t < done_t) begin
        chk("busy", host_if.busy, 1);
        chk("ss_n", ss_n, 0);
        chk("done", host_if.done, 0);
        chk("sck", sck, exp_phase(t, m_p) ^ m_pol);
        idx = exp_idx(t, m_p, m_pha);
        if (idx >= 0) chk("mosi", mosi, m_lsb ? m_tx[idx] : m_tx[DW-1-idx]);
      end else begin
        chk("done_pulse", host_if.done, 1);
        chk("done_busy", host_if.busy, 0);
        chk("done_ss_n", ss_n, 1);
        chk("done_mosi", mosi, 0);
        chk("done_sck", sck, m_pol);
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          exp_rx = exp_q.pop_front();
          chk("rx_data", host_if.rx_data, exp_rx);
        end
      end
    end else begin
      chk("idle_busy", host_if.busy, 0);
      chk("idle_done", host_if.done, 0);
      chk("idle_ss_n", ss_n, 1);
      chk("idle_mosi", mosi, 0);
      chk("idle_sck", sck, m_pol_last);
      chk("idle_rx", host_if.rx_data, m_rx_last);
    end
  end

  // ---------------- driver ----------------
  task automatic run_xfer(input logic [DW-1:0] tx, input logic [7:0] div, input logic pol,
                          input logic pha, input logic lsb, input int mode, input bit disturb,
                          output int edges, output logic [DW-1:0] mword, output int lat,
                          output int dones, output int ss_rise);
    logic prev_sck, prev_ss, leading;
    @(negedge clk);
    miso_mode         = mode;
    host_if.tx_data   = tx;
    host_if.baud_div  = div;
    host_if.cpol      = pol;
    host_if.cpha      = pha;
    host_if.lsb_first = lsb;
    host_if.start     = 1'b1;
    @(negedge clk);
    host_if.start = 1'b0;
    chk("accept_busy", host_if.busy, 1);
    edges = 0; mword = '0; lat = -1; dones = 0; ss_rise = 0;
    prev_sck = sck;
    prev_ss  = ss_n;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (disturb && c == 6) begin
        host_if.start    = 1'b1;
        host_if.cpol     = ~pol;
        host_if.baud_div = div + 8'd3;
      end
      if (disturb && c == 7) host_if.start = 1'b0;
      if (sck !== prev_sck) begin
        edges++;
        leading = (prev_sck == pol);
        if (pha ? !leading : leading) mword = {mword[DW-2:0], mosi};
      end
      if (host_if.done) begin
        dones++;
        if (lat < 0) lat = c;
      end
      if (ss_n && !prev_ss) ss_rise++;
      prev_sck = sck;
      prev_ss  = ss_n;
      if (lat >= 0 && c >= lat + 8) break;
    end
  endtask

  typedef struct {
    logic [DW-1:0] tx;
    logic [7:0]    div;
    logic          pol;
    logic          pha;
    logic          lsb;
    int            mode;
    logic [DW-1:0] rx;
    int            lat;
    logic [DW-1:0] mw;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int e, l, d, s, ec;
    logic [DW-1:0] w;
    logic ps;

    vecs[0] = '{8'h1F, 8'd2, 1'b0, 1'b1, 1'b0, 1, 8'h1F, 54, 8'h1F};
    vecs[1] = '{8'hC2, 8'd0, 1'b1, 1'b0, 1'b1, 2, 8'h3D, 18, 8'h43};
    vecs[2] = '{8'h96, 8'd3, 1'b1, 1'b1, 1'b0, 0, 8'h00, 72, 8'h96};
    vecs[3] = '{8'h4B, 8'd1, 1'b0, 1'b0, 1'b1, 1, 8'h4B, 36, 8'hD2};

    rst_n             = 1'b1;
    miso_mode         = 0;
    host_if.start     = 1'b0;
    host_if.tx_data   = '0;
    host_if.baud_div  = '0;
    host_if.cpol      = 1'b0;
    host_if.cpha      = 1'b0;
    host_if.lsb_first = 1'b0;
`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
    loopback          = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2;
    chk("lit_rst_ss_n", ss_n, 1);
    chk("lit_rst_sck", sck, 0);
    chk("lit_rst_busy", host_if.busy, 0);
    chk("lit_rst_rx", host_if.rx_data, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Mode 0, MSB first, baud_div=1, loopback wiring
    run_xfer(8'hA5, 8'd1, 1'b0, 1'b0, 1'b0, 1, 1'b0, e, w, l, d, s);
    chk("m0_edges", e, 16);
    chk("m0_mosi_seq", w, 8'hA5);
    chk("m0_latency", l, 36);
    chk("m0_rx", host_if.rx_data, 8'hA5);
    chk("m0_dones", d, 1);

    // Mode 3, LSB first, baud_div=0, miso held high
    run_xfer(8'h3C, 8'd0, 1'b1, 1'b1, 1'b1, 3, 1'b0, e, w, l, d, s);
    chk("m3_edges", e, 16);
    chk("m3_mosi_seq", w, 8'h3C);
    chk("m3_latency", l, 18);
    chk("m3_rx", host_if.rx_data, 8'hFF);
    chk("m3_sck_idle", sck, 1);

    for (int i = 0; i < 4; i++) begin
      run_xfer(vecs[i].tx, vecs[i].div, vecs[i].pol, vecs[i].pha, vecs[i].lsb, vecs[i].mode,
               1'b0, e, w, l, d, s);
      chk($sformatf("vec%0d_edges", i), e, 16);
      chk($sformatf("vec%0d_mosi_seq", i), w, vecs[i].mw);
      chk($sformatf("vec%0d_latency", i), l, vecs[i].lat);
      chk($sformatf("vec%0d_rx", i), host_if.rx_data, vecs[i].rx);
    end

    // Second start plus cpol/baud_div changes mid-transfer must not disturb it
    run_xfer(8'h69, 8'd2, 1'b0, 1'b1, 1'b0, 1, 1'b1, e, w, l, d, s);
    chk("dist_edges", e, 16);
    chk("dist_latency", l, 54);
    chk("dist_dones", d, 1);
    chk("dist_ss_rise", s, 1);
    chk("dist_rx", host_if.rx_data, 8'h69);
    // The changed settings now apply: cpol=1, baud_div=5
    run_xfer(8'h81, 8'd5, 1'b1, 1'b0, 1'b0, 1, 1'b0, e, w, l, d, s);
    chk("next_latency", l, 108);
    chk("next_sck_idle", sck, 1);
    chk("next_rx", host_if.rx_data, 8'h81);

    // Reset after the fifth sck edge aborts the transfer
    @(negedge clk);
    miso_mode         = 1;
    host_if.tx_data   = 8'hC3;
    host_if.baud_div  = 8'd1;
    host_if.cpol      = 1'b0;
    host_if.cpha      = 1'b0;
    host_if.lsb_first = 1'b0;
    host_if.start     = 1'b1;
    @(negedge clk);
    host_if.start = 1'b0;
    ec = 0;
    ps = sck;
    for (int c = 0; c < 200 && ec < 5; c++) begin
      @(negedge clk);
      if (sck !== ps) ec++;
      ps = sck;
    end
    chk("abort_edges_seen", ec, 5);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_ss_n", ss_n, 1);
    chk("abort_sck", sck, 0);
    chk("abort_busy", host_if.busy, 0);
    chk("abort_rx", host_if.rx_data, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    d = 0;
    repeat (20) begin
      @(negedge clk);
      if (host_if.done) d++;
    end
    chk("abort_no_done", d, 0);
    run_xfer(8'hC3, 8'd1, 1'b0, 1'b0, 1'b0, 1, 1'b0, e, w, l, d, s);
    chk("post_rst_latency", l, 36);
    chk("post_rst_mosi_seq", w, 8'hC3);
    chk("post_rst_rx", host_if.rx_data, 8'hC3);

`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
    loopback = 1'b1;
    run_xfer(8'h5A, 8'd1, 1'b0, 1'b0, 1'b0, 0, 1'b0, e, w, l, d, s);
    chk("lb_rx", host_if.rx_data, 8'h5A);
    chk("lb_edges", e, 16);
    @(negedge clk);
    loopback = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the transfer word width in bits (legal range 4..32).
REQ-002 SHALL have parameter DIV_W, default 8, giving the baud divider width.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: transfer request, sampled only in IDLE.
REQ-006 SHALL have port tx_data, input, DATA_W bits: word to transmit, latched on start acceptance.
REQ-007 SHALL have port baud_div, input, DIV_W bits: SCK half-period equals baud_div+1 clk cycles.
REQ-008 SHALL have ports cpol, cpha, lsb_first, inputs, 1 bit each: SPI mode and bit order.
REQ-009 SHALL have port miso, input, 1 bit: serial data in.
REQ-010 SHALL have port sck, output, 1 bit: serial clock.
REQ-011 SHALL have port mosi, output, 1 bit: serial data out.
REQ-012 SHALL have port ss_n, output, 1 bit: active-low slave select.
REQ-013 SHALL have port busy, output, 1 bit: high from start acceptance until the cycle done pulses.
REQ-014 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-015 SHALL have port rx_data, output, DATA_W bits: last received word.

Function
REQ-016 SHALL implement the states IDLE, SETUP, XFER, HOLD and DONE.
REQ-017 IDLE: start=1 SHALL latch tx_data, baud_div, cpol, cpha and lsb_first, then move to SETUP; the latched values SHALL stay fixed for the whole transfer.
REQ-018 SETUP SHALL drive ss_n=0, last baud_div+1 cycles, then move to XFER.
REQ-019 XFER SHALL produce exactly 2*DATA_W SCK edges, one every baud_div+1 cycles, then move to HOLD.
REQ-020 HOLD SHALL keep ss_n=0 and sck at idle level for baud_div+1 cycles, then move to DONE.
REQ-021 DONE SHALL last 1 cycle with done=1, ss_n=1 and busy=0, update rx_data in that cycle, then return to IDLE.
REQ-022 sck SHALL equal internal phase XOR latched cpol; the internal phase SHALL be 0 outside XFER.
REQ-023 cpha=0: the first bit SHALL be on mosi from SETUP entry; sample on each leading edge; shift on each trailing edge.
REQ-024 cpha=1: shift on each leading edge, including the first; sample on each trailing edge.
REQ-025 lsb_first=1 SHALL transmit and assemble bit 0 first; otherwise bit DATA_W-1 first.
REQ-026 The divider counter SHALL count down from baud_div to 0 and reload on wrap; baud_div=0 SHALL give one edge per clk cycle.
REQ-027 start while busy=1 SHALL be ignored, with no queuing.
REQ-028 mosi SHALL be 0 in IDLE and DONE.
REQ-029 Latency: done SHALL rise exactly (2*DATA_W+2)*(baud_div+1) cycles after busy first rises.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, sck=0 (internal phase 0), mosi=0, ss_n=1, busy=0, done=0, rx_data=0, and clear all counters.
REQ-031 Reset mid-transfer SHALL abort without a done pulse; rx_data SHALL read 0.
REQ-032 Reset release SHALL take effect synchronously at the next clk edge, with no spurious sck edge.

Configuration
REQ-033 With macro SPI_MASTER_CTRL_LOOPBACK_EN defined, the block SHALL have an extra input loopback (1 bit); when loopback=1, the sampled bit SHALL be the internal mosi instead of miso, and sck/ss_n SHALL behave unchanged.
REQ-034 Without SPI_MASTER_CTRL_LOOPBACK_EN, the loopback port SHALL be absent and miso SHALL always be sampled.

Verification
REQ-035 Mode 0, MSB first, baud_div=1, tx_data=0xA5, miso tied to mosi externally -> 16 sck edges at 2-cycle spacing, mosi sequence 1,0,1,0,0,1,0,1, rx_data=0xA5, done 36 cycles after busy rises.
REQ-036 Mode 3 (cpol=1, cpha=1), lsb_first=1, baud_div=0, tx_data=0x3C, miso constant 1 -> sck idles high, mosi 0,0,1,1,1,1,0,0, rx_data=0xFF, done 18 cycles after busy rises.
REQ-037 Second start pulse during XFER -> ignored; exactly one done pulse; ss_n toggles once low-then-high.
REQ-038 rst_n=0 after the 5th sck edge -> ss_n=1, sck=0, busy=0 immediately; no done pulse; a subsequent start runs a full correct transfer.
REQ-039 With SPI_MASTER_CTRL_LOOPBACK_EN, loopback=1, miso=0, tx_data=0x5A -> rx_data=0x5A.
REQ-040 cpol/baud_div changed mid-transfer -> no effect on the current sck timing or level; the new values apply to the next transfer.
